clk_en_gen: RTL and testbench

Multi-channel programmable clock-enable generator. Runs on the single system clock and replaces derived ripple clocks with N_CH single-cycle tick strobes. It also produces N_CH 50%-duty phase signals for slow-logic enables and display timing. Divisors are reprogrammable at run time through a valid/ready write port, with glitch-free update at the terminal count. A global sync input realigns all channels.

---
 rtl/clk_en_pkg.sv | 17 +
 rtl/clk_en_channel.sv | 77 +++++++
 rtl/clk_en_gen.sv | 53 +++++
 tb/tb_clk_en_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_en_pkg.sv
// Shared constants and helpers for the clock-enable generator.
package clk_en_pkg;

   // Defaults used when the generator is instantiated without overrides.
   localparam int N_CH_DEFAULT    = 4;
   localparam int CW_DEFAULT      = 16;
   localparam int DEF_DIV_DEFAULT = 2;

   // A divisor of zero parks a channel: no ticks, phase frozen.
   localparam int DIV_DISABLED = 0;

   // Channel-select width; a single channel still gets a 1-bit select.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_en_channel.sv
// One clock-enable channel: divisor counter, tick strobe, half-rate phase,
// and a single-entry pending divisor that is applied only at a period
// boundary so no period is ever truncated or stretched.
module clk_en_channel
   import clk_en_pkg::*;
#(
   parameter int CW      = CW_DEFAULT,
   parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sync,
   input  logic          wr,
   input  logic [CW-1:0] wr_div,
   output logic          pend,
   output logic          tick,
   output logic          phase
);

   logic [CW-1:0] cnt;
   logic [CW-1:0] div;
   logic [CW-1:0] pend_div;
   logic          disabled;
   logic          terminal;

   assign disabled = (div == CW'(DIV_DISABLED));
   // Only meaningful when not disabled, so div-1 never underflows in use.
   assign terminal = (cnt == div - CW'(1));

   // Counter, strobe, phase and divisor update with sync > disable > terminal priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         div      <= CW'(DEF_DIV);
         pend_div <= '0;
         pend     <= 1'b0;
         tick     <= 1'b0;
         phase    <= 1'b0;
      end else if (sync) begin
         // NOTE: non-blocking assignments keep every register reading the
         // pre-edge values, so the pend/div handover below is order-independent.
         cnt   <= '0;
         tick  <= 1'b0;
         phase <= 1'b0;
         if (wr) begin
            div  <= wr_div;
            pend <= 1'b0;
         end else if (pend) begin
            div  <= pend_div;
            pend <= 1'b0;
         end
      end else begin
         if (disabled) begin
            cnt  <= '0;
            tick <= 1'b0;
         end else if (terminal) begin
            cnt   <= '0;
            tick  <= 1'b1;
            phase <= ~phase;
         end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
         end
         if (pend && (disabled || terminal)) begin
            div  <= pend_div;
            pend <= 1'b0;
         end
         // wr is only ever raised while pend is low, so it never races the
         // consumption above.
         if (wr) begin
            pend_div <= wr_div;
            pend     <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel programmable clock-enable generator: N_CH independent
// divider channels sharing one valid/ready divisor write port and a
// global realign strobe.
module clk_en_gen
   import clk_en_pkg::*;
#(
   parameter  int N_CH    = N_CH_DEFAULT,
   parameter  int CW      = CW_DEFAULT,
   parameter  int DEF_DIV = DEF_DIV_DEFAULT,
   localparam int CHW     = ch_width(N_CH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            sync_i,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [CHW-1:0]  cfg_ch,
   input  logic [CW-1:0]   cfg_div,
   output logic [N_CH-1:0] tick,
   output logic [N_CH-1:0] phase
);

   logic [N_CH-1:0]       pend;
   logic [N_CH-1:0]       wr;
   logic [(1<<CHW)-1:0]   pend_ext;

   // Pad pend to the full select range so unused channel codes read as ready.
   always_comb begin
      pend_ext             = '0;
      pend_ext[N_CH-1:0]   = pend;
      cfg_ready            = ~pend_ext[cfg_ch];
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      // Out-of-range selects match no channel, so those writes are dropped.
      assign wr[i] = cfg_valid & cfg_ready & (cfg_ch == CHW'(i));

      clk_en_channel #(
         .CW      (CW),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .sync   (sync_i),
         .wr     (wr[i]),
         .wr_div (cfg_div),
         .pend   (pend[i]),
         .tick   (tick[i]),
         .phase  (phase[i])
      );
   end

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen: table-driven default pattern plus
// scoreboarded multi-cycle sequences against a countdown reference model.
module tb_clk_en_gen;

   localparam int N_CH    = 4;
   localparam int CW      = 16;
   localparam int DEF_DIV = 2;
   localparam int CHW     = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            sync_i = 1'b0;
   logic            cfg_valid = 1'b0;
   logic            cfg_ready;
   logic [CHW-1:0]  cfg_ch = '0;
   logic [CW-1:0]   cfg_div = '0;
   logic [N_CH-1:0] tick;
   logic [N_CH-1:0] phase;

   always #5 clk = ~clk;

   clk_en_gen #(
      .N_CH    (N_CH),
      .CW      (CW),
      .DEF_DIV (DEF_DIV)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sync_i    (sync_i),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .tick      (tick),
      .phase     (phase)
   );

   typedef struct packed {
      logic [N_CH-1:0] tick;
      logic [N_CH-1:0] phase;
   } exp_t;

   typedef struct {
      logic            sync;
      logic            valid;
      int              ch;
      int              div;
      logic [N_CH-1:0] exp_tick;
      logic [N_CH-1:0] exp_phase;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[20];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: counts down the edges left until the terminal edge.
   int m_div[N_CH];
   int m_left[N_CH];
   int m_pdiv[N_CH];
   bit m_pend[N_CH];
   bit m_phase[N_CH];
   bit m_tick[N_CH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N_CH; i++) begin
         m_div[i]   = DEF_DIV;
         m_left[i]  = DEF_DIV;
         m_pdiv[i]  = 0;
         m_pend[i]  = 1'b0;
         m_phase[i] = 1'b0;
         m_tick[i]  = 1'b0;
      end
   endfunction

   function automatic bit model_ready(input int ch);
      return (ch >= N_CH) ? 1'b1 : !m_pend[ch];
   endfunction

   function automatic void model_edge(input bit s, input bit v, input int ch, input int d);
      for (int i = 0; i < N_CH; i++) begin
         bit acc;
         acc = v && (i == ch) && !m_pend[i];
         if (s) begin
            m_tick[i]  = 1'b0;
            m_phase[i] = 1'b0;
            if (acc) m_div[i] = d;
            else if (m_pend[i]) begin
               m_div[i]  = m_pdiv[i];
               m_pend[i] = 1'b0;
            end
            m_left[i] = m_div[i];
         end else begin
            if (m_div[i] == 0) begin
               m_tick[i] = 1'b0;
               if (m_pend[i]) begin
                  m_div[i]  = m_pdiv[i];
                  m_pend[i] = 1'b0;
                  m_left[i] = m_div[i];
               end
            end else if (m_left[i] == 1) begin
               m_tick[i]  = 1'b1;
               m_phase[i] = !m_phase[i];
               if (m_pend[i]) begin
                  m_div[i]  = m_pdiv[i];
                  m_pend[i] = 1'b0;
               end
               m_left[i] = m_div[i];
            end else begin
               m_left[i] = m_left[i] - 1;
               m_tick[i] = 1'b0;
            end
            if (acc) begin
               m_pend[i] = 1'b1;
               m_pdiv[i] = d;
            end
         end
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      for (int i = 0; i < N_CH; i++) begin
         e.tick[i]  = m_tick[i];
         e.phase[i] = m_phase[i];
      end
      return e;
   endfunction

   // One clock: drive inputs, check ready, predict, then compare after the edge.
   task automatic step(input bit s, input bit v, input int ch, input int d, output bit acc);
      exp_t e;
      sync_i    = s;
      cfg_valid = v;
      cfg_ch    = CHW'(ch);
      cfg_div   = CW'(d);
      #1;
      check("cfg_ready", cfg_ready, model_ready(ch));
      acc = v && model_ready(ch) && (ch < N_CH);
      model_edge(s, v, ch, d);
      sb_q.push_back(model_out());
      @(posedge clk);
      #1;
      sync_i    = 1'b0;
      cfg_valid = 1'b0;
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 1, 0);
      end else begin
         e = sb_q.pop_front();
         check("tick", tick, e.tick);
         check("phase", phase, e.phase);
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0, acc);
   endtask

   task automatic write_div(input int ch, input int d);
      bit acc;
      acc = 1'b0;
      for (int k = 0; k < 64 && !acc; k++) step(1'b0, 1'b1, ch, d, acc);
      if (!acc) check("write_accept_timeout", 0, 1);
   endtask

   task automatic run_table();
      bit acc;
      for (int k = 0; k < 20; k++) begin
         step(vecs[k].sync, vecs[k].valid, vecs[k].ch, vecs[k].div, acc);
         check("tbl_tick", tick, vecs[k].exp_tick);
         check("tbl_phase", phase, vecs[k].exp_phase);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      // Default pattern after reset: every channel ticks on even edges.
      for (int k = 0; k < 20; k++) begin
         int e;
         e = k + 1;
         vecs[k].sync      = 1'b0;
         vecs[k].valid     = 1'b0;
         vecs[k].ch        = 0;
         vecs[k].div       = 0;
         vecs[k].exp_tick  = (e % 2 == 0) ? 4'hF : 4'h0;
         vecs[k].exp_phase = ((e / 2) % 2 == 1) ? 4'hF : 4'h0;
      end

      model_reset();
      #23;
      check("rst_tick", tick, 0);
      check("rst_phase", phase, 0);
      check("rst_ready", cfg_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      run_table();

      // ch1 -> 5 while mid-period; update lands on a period boundary.
      idle(1);
      write_div(1, 5);
      cfg_ch = 2'd1;
      #1;
      check("ch1_pending_ready", cfg_ready, 0);
      idle(16);

      // ch2 disabled, then re-enabled with divisor 3.
      write_div(2, 0);
      idle(6);
      write_div(2, 3);
      idle(10);

      // ch3 -> 7, then realign everything at an odd offset.
      write_div(3, 7);
      idle(3);
      step(1'b1, 1'b0, 0, 0, acc);
      check("sync_tick", tick, 0);
      check("sync_phase", phase, 0);
      idle(20);

      // ch0 -> 1: continuous tick, phase toggles every cycle.
      write_div(0, 1);
      idle(4);
      check("div1_tick0", tick[0], 1);
      idle(6);

      // Reset mid-period with ch1 holding a pending write.
      write_div(1, 9);
      cfg_ch = 2'd1;
      #1;
      check("pend_before_rst", cfg_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_tick", tick, 0);
      check("async_rst_phase", phase, 0);
      check("async_rst_ready", cfg_ready, 1);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_table();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
